score_bcd_converter: RTL

- Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle) between the score tracker's 7-bit score output and the seven-segment decoders.
- Converts a registered snapshot of the score into packed BCD digits.
- Holds the last valid result stable for the display while a new conversion runs.
- Replaces the combinational adder-based conversion, which is incorrect above 9.

---
 rtl/score_bcd_converter.sv | 117 +++++++++++
 1 files changed

// File: rtl/score_bcd_converter.sv
// score_bcd_converter
//   Sequential binary-to-BCD converter (shift-and-add-3, one input bit per
//   clock). Sits between the score tracker and the seven-segment decoders.
//   A snapshot of `value` is taken when a conversion is accepted, and
//   bcd_out holds the previous result until the new one is complete.
//
// Ports:
//   clk      in   system clock
//   nRst     in   asynchronous active-low reset
//   value    in   [IN_W-1:0] binary value to convert
//   start    in   conversion request (ignored while busy)
//   bcd_out  out  [4*DIGITS-1:0] packed BCD, digit 0 (ones) in [3:0]
//   busy     out  conversion in progress
//   done     out  one-cycle pulse in the cycle bcd_out takes a new value
//
// Optional feature (macro AUTO_CONVERT_EN):
//   When defined, a conversion starts by itself in IDLE whenever value
//   differs from the last accepted snapshot; the start port is ignored.
//   Undefined (default): conversions start only on start=1 in IDLE.
//
// DIGITS must satisfy 10^DIGITS > 2^IN_W - 1; otherwise upper digits are
// silently lost.

module score_bcd_converter #(
    parameter int IN_W   = 7,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic [IN_W-1:0]       value,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy,
    output logic                  done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [IN_W-1:0]   sreg;
    logic [BCD_W-1:0]  acc;
    logic [BCD_W-1:0]  acc_adj;
    logic [CNT_W-1:0]  cnt;
    logic              accept;

`ifdef AUTO_CONVERT_EN
    logic [IN_W-1:0]   last_value;
    assign accept = (value != last_value);
`else
    assign accept = start;
`endif

    // Add-3 correction per digit, no carry between digits. Applied before
    // the shift so a digit >= 5 rolls over into the next digit on shifting.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5)
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= IDLE;
            sreg    <= '0;
            acc     <= '0;
            cnt     <= '0;
            bcd_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef AUTO_CONVERT_EN
            last_value <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg  <= value;
                        acc   <= '0;
                        cnt   <= CNT_W'(IN_W);
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef AUTO_CONVERT_EN
                        last_value <= value;
`endif
                    end
                end
                SHIFT: begin
                    // MSB of the shift register enters accumulator bit 0;
                    // the top accumulator bit falls off by truncation.
                    acc  <= BCD_W'({acc_adj, sreg[IN_W-1]});
                    sreg <= {sreg[IN_W-2:0], 1'b0};
                    cnt  <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    bcd_out <= acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
